// File: rtl/bus_arb_pkg.sv
// Shared definitions for the system-bus arbiter and future bus blocks:
// FSM encodings, counter sizing and bus field widths.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        BUSY    = 2'd2,
        ABORT   = 2'd3
    } arb_state_e;

    localparam int BUS_ADDR_WIDTH  = 32;
    localparam int BUS_DATA_WIDTH  = 32;
    localparam int BUS_BE_WIDTH    = 4;
    localparam int BUS_BURST_WIDTH = 8;

    // One spare bit above the larger timeout so the counter can saturate
    // past its compare value without ever wrapping back to a match.
    function automatic int counter_width(input int grant_timeout, input int bus_timeout);
        int largest;
        largest = (grant_timeout > bus_timeout) ? grant_timeout : bus_timeout;
        return $clog2(largest) + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester found when scanning
// upward from last_index+1, wrapping at NUM.
module rr_pick #(
    parameter int NUM = 4,
    parameter int IW  = $clog2(NUM)
) (
    input  logic [NUM-1:0] request,
    input  logic [IW-1:0]  last_index,
    output logic [NUM-1:0] winner,
    output logic [IW-1:0]  winner_index,
    output logic           any_valid
);

    int          idx;
    logic [IW-1:0] sel;

    // NOTE: every output is given a default before the scan so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        winner       = '0;
        winner_index = '0;
        any_valid    = 1'b0;
        idx          = 0;
        sel          = '0;
        for (int off = 1; off <= NUM; off++) begin
            idx = (int'(last_index) + off) % NUM;
            sel = IW'(idx);
            if (!any_valid && request[sel]) begin
                winner[sel]  = 1'b1;
                winner_index = sel;
                any_valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbitration for the shared system bus, with grant
// timeout and a transaction watchdog that terminates hung transfers.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS   = 4,
    parameter int GRANT_TIMEOUT = 16,
    parameter int BUS_TIMEOUT   = 256
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_MASTERS-1:0]         request_i,
    output logic [NUM_MASTERS-1:0]         grant_o,
    output logic [$clog2(NUM_MASTERS)-1:0] activeMaster_o,
    input  logic                           bus_beginTransaction_i,
    input  logic                           bus_endTransaction_i,
    input  logic                           bus_error_i,
    output logic                           bus_endTransaction_o,
    output logic                           bus_error_o,
    output logic                           busIdle_o
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int CW = counter_width(GRANT_TIMEOUT, BUS_TIMEOUT);

    localparam logic [CW-1:0] GRANT_LIMIT = CW'(GRANT_TIMEOUT - 1);
    localparam bit            WDOG_EN     = (BUS_TIMEOUT != 0);
    localparam logic [CW-1:0] BUS_LIMIT   = WDOG_EN ? CW'(BUS_TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX     = '1;

    arb_state_e             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          active_q, active_d;
    logic [IW-1:0]          last_q, last_d;
    logic                   err_q, err_d;
    logic                   end_q, end_d;

    logic [NUM_MASTERS-1:0] pick_grant;
    logic [IW-1:0]          pick_index;
    logic                   pick_valid;

    rr_pick #(
        .NUM (NUM_MASTERS),
        .IW  (IW)
    ) u_rr_pick (
        .request      (request_i),
        .last_index   (last_q),
        .winner       (pick_grant),
        .winner_index (pick_index),
        .any_valid    (pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        grant_d  = grant_q;
        active_d = active_q;
        last_d   = last_q;
        err_d    = 1'b0;
        end_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_valid) begin
                    state_d  = GRANTED;
                    grant_d  = pick_grant;
                    active_d = pick_index;
                    last_d   = pick_index;
                end
            end
            GRANTED: begin
                // Begin takes priority over a simultaneous request drop.
                if (bus_beginTransaction_i) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end else if (!request_i[active_q] || cnt_q == GRANT_LIMIT) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (bus_endTransaction_i || bus_error_i) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (WDOG_EN && cnt_q == BUS_LIMIT) begin
                    state_d = ABORT;
                    err_d   = 1'b1;
                    end_d   = 1'b1;
                end
            end
            ABORT: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            grant_q  <= '0;
            active_q <= '0;
            last_q   <= IW'(NUM_MASTERS - 1);
            err_q    <= 1'b0;
            end_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            active_q <= active_d;
            last_q   <= last_d;
            err_q    <= err_d;
            end_q    <= end_d;
        end
    end

    assign grant_o              = grant_q;
    assign activeMaster_o       = active_q;
    assign bus_error_o          = err_q;
    assign bus_endTransaction_o = end_q;
    assign busIdle_o            = (state_q == IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: expected grants are queued as requests are
// driven and popped when the arbiter issues a grant.
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  request = '0;
    logic [N-1:0]  grant;
    logic [IW-1:0] active;
    logic          begin_i = 1'b0;
    logic          end_i = 1'b0;
    logic          error_i = 1'b0;
    logic          end_o;
    logic          error_o;
    logic          idle;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [N-1:0]  grant;
        logic [IW-1:0] index;
    } exp_t;

    exp_t sb[$];

    bus_arbiter #(
        .NUM_MASTERS   (N),
        .GRANT_TIMEOUT (16),
        .BUS_TIMEOUT   (8)
    ) dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .request_i              (request),
        .grant_o                (grant),
        .activeMaster_o         (active),
        .bus_beginTransaction_i (begin_i),
        .bus_endTransaction_i   (end_i),
        .bus_error_i            (error_i),
        .bus_endTransaction_o   (end_o),
        .bus_error_o            (error_o),
        .busIdle_o              (idle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " grant"}, 32'(grant), 32'h0);
        check({tag, " active"}, 32'(active), 32'h0);
        check({tag, " error_o"}, 32'(error_o), 32'h0);
        check({tag, " end_o"}, 32'(end_o), 32'h0);
        check({tag, " idle"}, 32'(idle), 32'h1);
    endtask

    task automatic push_exp(input int index);
        exp_t e;
        e.grant = N'(1) << index;
        e.index = IW'(index);
        sb.push_back(e);
    endtask

    // Waits a bounded number of cycles for a grant, then compares it with the
    // oldest queued expectation.
    task automatic wait_grant(input string tag, input int max_cycles);
        exp_t e;
        int   n;
        n = 0;
        while (grant == '0 && n < max_cycles) begin
            tick();
            n++;
        end
        if (sb.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'(sb.size()), 32'h1);
        end else begin
            e = sb.pop_front();
            check({tag, " grant"}, 32'(grant), 32'(e.grant));
            check({tag, " active"}, 32'(active), 32'(e.index));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen_err;
        logic prev_grant_zero;

        // Reset state
        do_reset();
        check_reset_outputs("reset");

        // Single master, exact one-cycle grant latency, normal end
        request = 4'b0001;
        push_exp(0);
        tick();
        wait_grant("t1", 0);
        check("t1 not idle", 32'(idle), 32'h0);
        begin_i = 1'b1;
        tick();
        begin_i = 1'b0;
        repeat (4) tick();
        check("t1 held busy", 32'(grant), 32'h1);
        end_i = 1'b1;
        tick();
        end_i = 1'b0;
        request = '0;
        check("t1 released", 32'(grant), 32'h0);
        check("t1 idle", 32'(idle), 32'h1);
        check("t1 no error", 32'(error_o), 32'h0);

        // Round-robin order 0,1,2,3,0 with all requests held
        do_reset();
        request = 4'b1111;
        for (int i = 0; i < 5; i++) push_exp(i % N);
        for (int i = 0; i < 5; i++) begin
            prev_grant_zero = (grant == '0);
            check($sformatf("rr%0d gap before", i), 32'(prev_grant_zero), 32'h1);
            wait_grant($sformatf("rr%0d", i), 4);
            begin_i = 1'b1;
            tick();
            begin_i = 1'b0;
            tick();
            end_i = 1'b1;
            tick();
            end_i = 1'b0;
            check($sformatf("rr%0d turnaround", i), 32'(grant), 32'h0);
        end
        request = '0;
        tick();

        // Grant timeout: master 2 never begins
        request = 4'b0100;
        push_exp(2);
        wait_grant("gto", 4);
        seen_err = 1'b0;
        repeat (15) begin
            tick();
            seen_err |= error_o;
        end
        check("gto still granted", 32'(grant), 32'h4);
        tick();
        seen_err |= error_o;
        request = '0;
        check("gto revoked", 32'(grant), 32'h0);
        check("gto no error", 32'(seen_err), 32'h0);
        tick();

        // Watchdog abort after 8 cycles with no end
        request = 4'b0001;
        push_exp(0);
        wait_grant("wd", 4);
        begin_i = 1'b1;
        tick();
        begin_i = 1'b0;
        seen_err = 1'b0;
        repeat (7) begin
            tick();
            seen_err |= error_o | end_o;
        end
        check("wd quiet before", 32'(seen_err), 32'h0);
        tick();
        check("wd error pulse", 32'(error_o), 32'h1);
        check("wd end pulse", 32'(end_o), 32'h1);
        check("wd grant held", 32'(grant), 32'h1);
        tick();
        request = '0;
        check("wd error clear", 32'(error_o), 32'h0);
        check("wd end clear", 32'(end_o), 32'h0);
        check("wd grant clear", 32'(grant), 32'h0);
        tick();

        // End arriving on the timeout cycle wins
        request = 4'b0010;
        push_exp(1);
        wait_grant("race", 4);
        begin_i = 1'b1;
        tick();
        begin_i = 1'b0;
        repeat (7) tick();
        end_i = 1'b1;
        tick();
        end_i = 1'b0;
        request = '0;
        check("race no error", 32'(error_o), 32'h0);
        check("race no end_o", 32'(end_o), 32'h0);
        check("race released", 32'(grant), 32'h0);
        check("race idle", 32'(idle), 32'h1);
        tick();

        // Slave error terminates the transaction without a watchdog error
        request = 4'b0100;
        push_exp(2);
        wait_grant("slverr", 4);
        begin_i = 1'b1;
        tick();
        begin_i = 1'b0;
        tick();
        error_i = 1'b1;
        tick();
        error_i = 1'b0;
        request = '0;
        check("slverr released", 32'(grant), 32'h0);
        check("slverr no error_o", 32'(error_o), 32'h0);
        tick();

        // Reset mid-transaction, then master 0 wins over master 3
        request = 4'b1000;
        push_exp(3);
        wait_grant("rstbusy", 4);
        begin_i = 1'b1;
        tick();
        begin_i = 1'b0;
        tick();
        check("rstbusy busy", 32'(idle), 32'h0);
        rst = 1'b1;
        tick();
        check_reset_outputs("rstbusy");
        request = 4'b1001;
        rst = 1'b0;
        push_exp(0);
        wait_grant("post reset", 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter for the single shared system bus (beginTransaction/endTransaction/addressData/…/busError).
- Grants bus ownership to one of NUM_MASTERS requesters at a time and tracks each transaction from begin to end.
- Includes a watchdog: a transaction with no endTransaction within BUS_TIMEOUT cycles is terminated with a bus error.
- Sits between the masters (CPU, DMA, camera, display) and the bus OR-tree; slaves are unaffected.

Parameters:
- NUM_MASTERS, 4, number of requesters, range 2..16.
- GRANT_TIMEOUT, 16, max cycles a granted master may take to assert beginTransaction before the grant is revoked; minimum 2.
- BUS_TIMEOUT, 256, max cycles from begin to end before the watchdog fires; 0 disables the watchdog.

Ports:
- clk_i, input, 1, system clock.
- rst_i, input, 1, synchronous active-high reset.
- request_i, input, NUM_MASTERS, per-master bus request, level-held until the master's transaction ends.
- grant_o, output, NUM_MASTERS, one-hot bus grant, registered.
- activeMaster_o, output, clog2(NUM_MASTERS), index of the granted master; valid while grant_o != 0.
- bus_beginTransaction_i, input, 1, shared bus beginTransaction.
- bus_endTransaction_i, input, 1, shared bus endTransaction (from slave or master).
- bus_error_i, input, 1, shared bus error from a slave.
- bus_endTransaction_o, output, 1, watchdog-generated endTransaction, ORed into the bus.
- bus_error_o, output, 1, watchdog-generated bus error, ORed into the bus.
- busIdle_o, output, 1, high in IDLE.

Behaviour:
- One clock domain (clk_i); reset is synchronous and active-high.
- Reset values: grant_o=0, activeMaster_o=0, bus_endTransaction_o=0, bus_error_o=0, busIdle_o=1, state=IDLE, lastGrant=NUM_MASTERS-1, counter=0.
- States: IDLE, GRANTED, BUSY, ABORT.
- IDLE:
  - If request_i!=0, pick the winner by round-robin: first set bit scanning from index lastGrant+1 upward, wrapping at NUM_MASTERS.
  - grant_o, activeMaster_o and lastGrant are registered, so the grant is visible 1 cycle after request is sampled.
  - Go to GRANTED; counter=0.
- GRANTED:
  - bus_beginTransaction_i=1 -> BUSY, counter=0.
  - Granted master's request drops before begin -> IDLE, grant_o=0 next cycle.
  - counter reaches GRANT_TIMEOUT-1 with no begin -> IDLE, grant_o=0, no error.
  - Begin and request-drop in the same cycle: begin wins.
- BUSY:
  - bus_endTransaction_i=1 or bus_error_i=1 -> IDLE, grant_o=0 next cycle.
  - If BUS_TIMEOUT!=0 and counter reaches BUS_TIMEOUT-1 with no end -> ABORT.
  - End and timeout in the same cycle: end wins, no error.
  - Request drop in BUSY is ignored; the grant is held until end.
- ABORT (exactly 1 cycle):
  - bus_error_o=1, bus_endTransaction_o=1, grant_o still asserted.
  - Next cycle: outputs 0, grant_o=0, IDLE.
- Turnaround: grant_o is always 0 for at least 1 cycle between consecutive grants (IDLE cycle), even for back-to-back requests from the same master.
- Counter width is clog2(max(GRANT_TIMEOUT,BUS_TIMEOUT))+1; it saturates and never wraps.
- Glitches on bus_beginTransaction_i in IDLE or BUSY are ignored.
- busIdle_o is combinational from the state register.
- Reset asserted mid-transaction: all outputs return to reset values on the next edge; no ABORT pulse is emitted.

Decomposition:
- Shared package/include bus_arb_pkg holds:
  - state encodings (IDLE=0, GRANTED=1, BUSY=2, ABORT=3);
  - counter-width function;
  - bus signal width constants (address/data 32, byte enables 4, burst size 8) for reuse by future bus blocks.
- One sub-module: rr_pick, a combinational round-robin picker.
  - Inputs: request vector, last index.
  - Outputs: one-hot winner, winner index, any-valid.
  - Unit-testable alone.

Test Plan:
- Reset, then request_i=4'b0001 -> grant_o=4'b0001 1 cycle later. Begin, then end 5 cycles later -> grant_o=0 on the next cycle, busIdle_o=1.
- request_i=4'b1111 held, each granted master completing 3-cycle transactions -> grant order 0,1,2,3,0. At least 1 idle cycle between every pair of grants.
- Master 2 granted, 15 cycles with no begin (GRANT_TIMEOUT=16) -> still granted. 16th cycle with no begin -> grant_o=0, bus_error_o never asserted.
- BUS_TIMEOUT=8, begin with no end -> exactly 8 cycles after begin, bus_error_o=bus_endTransaction_o=1 for exactly 1 cycle, then grant_o=0.
- BUS_TIMEOUT=8, end arriving in the same cycle as the timeout -> bus_error_o stays 0 and the transaction ends normally. bus_error_i=1 in BUSY -> grant released, bus_error_o stays 0.
- rst_i asserted while BUSY with request_i=4'b1000 -> next cycle grant_o=0 and all outputs at reset values. After reset release, master 0 (request_i=4'b1001) wins before master 3.
